// File: rtl/sha512_block_buf_pkg.sv
// Shared constants and helpers for the SHA512 block assembly path.
// Block geometry, slot count and occupancy arithmetic live here.
package sha512_block_buf_pkg;
    localparam int SHA512_BLK_WORDS = 16;
    localparam int SHA512_WORD_W    = 64;
    localparam int SHA512_SLOTS     = 2;
    localparam int PROCB_TOTAL_MSB  = 127;
    localparam int IDX_W            = $clog2(SHA512_BLK_WORDS);
    localparam int ADDR_W           = $clog2(SHA512_SLOTS * SHA512_BLK_WORDS);
    localparam int FREE_W           = ADDR_W + 1;

    // Free word capacity: empty slots times block size, minus the partial block.
    function automatic logic [FREE_W-1:0] free_words(input logic [1:0] nfull,
                                                     input logic [IDX_W-1:0] cnt);
        logic [FREE_W-1:0] cap;
        cap = {{(FREE_W-2){1'b0}}, 2'd2 - nfull} << IDX_W;
        return cap - {{(FREE_W-IDX_W){1'b0}}, cnt};
    endfunction
endpackage

// File: rtl/sha512_block_ram.sv
// Simple dual-port RAM for the two block slots: one write port and a
// registered read port; storage itself is never reset.
module sha512_block_ram
    import sha512_block_buf_pkg::*;
(
    input  logic                     CLK,
    input  logic                     rst_n,
    input  logic                     we_i,
    input  logic [ADDR_W-1:0]        waddr_i,
    input  logic [SHA512_WORD_W-1:0] wdata_i,
    input  logic                     re_i,
    input  logic [ADDR_W-1:0]        raddr_i,
    output logic [SHA512_WORD_W-1:0] rdata_o
);
    localparam int DEPTH = SHA512_SLOTS * SHA512_BLK_WORDS;

    logic [SHA512_WORD_W-1:0] mem [DEPTH];
    logic [SHA512_WORD_W-1:0] rdata_q;

    always_ff @(posedge CLK) begin
        if (we_i)
            mem[waddr_i] <= wdata_i;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n)
            rdata_q <= '0;
        else if (re_i)
            rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/sha512_block_buf.sv
// Double-buffered 1024-bit block assembler feeding the SHA512 core.
// Collects 64-bit words into 16-word blocks held in two slots until released.
module sha512_block_buf
    import sha512_block_buf_pkg::*;
#(
    parameter int AFULL_WORDS = 4
) (
    input  logic                     CLK,
    input  logic                     rst_n,
    input  logic [SHA512_WORD_W-1:0] din,
    input  logic                     din_valid,
    input  logic                     din_last,
    output logic                     afull,
    output logic                     err,
    output logic                     blk_avail,
    output logic                     blk_last,
    input  logic [IDX_W-1:0]         rd_addr,
    input  logic                     rd_en,
    output logic [SHA512_WORD_W-1:0] dout,
    input  logic                     blk_done
);
    logic             wr_slot_q, wr_slot_d;
    logic             rd_slot_q, rd_slot_d;
    logic [IDX_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [1:0]       slot_full_q, slot_full_d;
    logic [1:0]       slot_last_q, slot_last_d;
    logic             err_q, err_d;
    logic             afull_q, afull_d;

    logic              wr_blocked, wr_accept, wr_wrap, release_blk;
    logic [1:0]        nfull_d;
    logic [FREE_W-1:0] free_d;

    always_comb begin
        wr_blocked  = slot_full_q[wr_slot_q];
        wr_accept   = din_valid & ~wr_blocked;
        wr_wrap     = wr_accept & (wr_cnt_q == IDX_W'(SHA512_BLK_WORDS - 1));
        release_blk = blk_done & slot_full_q[rd_slot_q];

        wr_slot_d   = wr_slot_q;
        rd_slot_d   = rd_slot_q;
        wr_cnt_d    = wr_cnt_q;
        slot_full_d = slot_full_q;
        slot_last_d = slot_last_q;

        // Release first, then fill: the write already saw the pre-release state.
        if (release_blk) begin
            slot_full_d[rd_slot_q] = 1'b0;
            slot_last_d[rd_slot_q] = 1'b0;
            rd_slot_d              = ~rd_slot_q;
        end
        if (wr_accept) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_wrap) begin
                slot_full_d[wr_slot_q] = 1'b1;
                slot_last_d[wr_slot_q] = din_last;
                wr_slot_d              = ~wr_slot_q;
            end
        end

        err_d   = err_q | (din_valid & wr_blocked) | (wr_accept & din_last & ~wr_wrap);
        nfull_d = {1'b0, slot_full_d[0]} + {1'b0, slot_full_d[1]};
        free_d  = free_words(nfull_d, wr_cnt_d);
        afull_d = (free_d <= FREE_W'(AFULL_WORDS));
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            wr_slot_q   <= 1'b0;
            rd_slot_q   <= 1'b0;
            wr_cnt_q    <= '0;
            slot_full_q <= '0;
            slot_last_q <= '0;
            err_q       <= 1'b0;
            afull_q     <= 1'b0;
        end else begin
            wr_slot_q   <= wr_slot_d;
            rd_slot_q   <= rd_slot_d;
            wr_cnt_q    <= wr_cnt_d;
            slot_full_q <= slot_full_d;
            slot_last_q <= slot_last_d;
            err_q       <= err_d;
            afull_q     <= afull_d;
        end
    end

    sha512_block_ram u_ram (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .we_i    (wr_accept),
        .waddr_i ({wr_slot_q, wr_cnt_q}),
        .wdata_i (din),
        .re_i    (rd_en),
        .raddr_i ({rd_slot_q, rd_addr}),
        .rdata_o (dout)
    );

    assign afull     = afull_q;
    assign err       = err_q;
    assign blk_avail = slot_full_q[rd_slot_q];
    assign blk_last  = slot_last_q[rd_slot_q];
endmodule

// File: tb/tb_sha512_block_buf.sv
// Directed bench for sha512_block_buf: expected read data goes through a
// scoreboard queue, flags are checked against values derived here.
module tb_sha512_block_buf;
    logic        CLK = 1'b0;
    logic        rst_n;
    logic [63:0] din;
    logic        din_valid;
    logic        din_last;
    logic        afull;
    logic        err;
    logic        blk_avail;
    logic        blk_last;
    logic [3:0]  rd_addr;
    logic        rd_en;
    logic [63:0] dout;
    logic        blk_done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] sb[$];

    sha512_block_buf #(.AFULL_WORDS(4)) dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_last  (din_last),
        .afull     (afull),
        .err       (err),
        .blk_avail (blk_avail),
        .blk_last  (blk_last),
        .rd_addr   (rd_addr),
        .rd_en     (rd_en),
        .dout      (dout),
        .blk_done  (blk_done)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [63:0] d, input logic last);
        din       = d;
        din_valid = 1'b1;
        din_last  = last;
        tick();
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    task automatic read_block(input logic [63:0] base, input string tag, input logic done_at_end);
        logic [63:0] exp;
        for (int i = 0; i < 16; i++) begin
            rd_en    = 1'b1;
            rd_addr  = 4'(i);
            blk_done = done_at_end && (i == 15);
            sb.push_back(base + 64'(i));
            tick();
            exp = sb.pop_front();
            chk(tag, dout, exp);
            $display("[TB] %s read idx=%0d dout=%h", tag, i, dout);
        end
        rd_en    = 1'b0;
        blk_done = 1'b0;
    endtask

    task automatic release_blk();
        blk_done = 1'b1;
        tick();
        blk_done = 1'b0;
    endtask

    task automatic sync_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; din = '0; din_valid = 1'b0; din_last = 1'b0;
        rd_addr = '0; rd_en = 1'b0; blk_done = 1'b0;
        tick(); tick();
        chk("rst_afull", 64'(afull), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_avail", 64'(blk_avail), 64'd0);
        chk("rst_last", 64'(blk_last), 64'd0);
        chk("rst_dout", dout, 64'd0);
        rst_n = 1'b1;
        tick();

        // One block of words 0..15, read back and released.
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("t1_avail_before", 64'(blk_avail), 64'd0);
            wr(64'(i), 1'b0);
        end
        chk("t1_avail", 64'(blk_avail), 64'd1);
        chk("t1_last", 64'(blk_last), 64'd0);
        read_block(64'h0, "t1_data", 1'b0);
        release_blk();
        chk("t1_avail_after", 64'(blk_avail), 64'd0);

        // Two blocks, last flag on word 31, afull tracking, then overflow.
        for (int n = 1; n <= 32; n++) begin
            wr(64'h100 + 64'(n - 1), n == 32);
            chk($sformatf("t2_afull_w%0d", n), 64'(afull), 64'((32 - n) <= 4));
        end
        chk("t2_avail", 64'(blk_avail), 64'd1);
        chk("t2_last_first", 64'(blk_last), 64'd0);
        chk("t2_err_pre", 64'(err), 64'd0);
        wr(64'hDEAD, 1'b0);
        chk("t3_err", 64'(err), 64'd1);
        read_block(64'h100, "t2_blkA", 1'b0);
        release_blk();
        chk("t2_last_second", 64'(blk_last), 64'd1);
        chk("t2_afull_rel", 64'(afull), 64'd0);
        read_block(64'h110, "t2_blkB", 1'b0);
        release_blk();
        chk("t2_empty", 64'(blk_avail), 64'd0);
        for (int i = 0; i < 16; i++) wr(64'h200 + 64'(i), 1'b0);
        chk("t3_avail", 64'(blk_avail), 64'd1);
        chk("t3_last", 64'(blk_last), 64'd0);
        read_block(64'h200, "t3_data", 1'b1);
        chk("t3_err_sticky", 64'(err), 64'd1);
        chk("t3_empty", 64'(blk_avail), 64'd0);

        // Misplaced last at index 5.
        sync_reset();
        chk("t4_err_rst", 64'(err), 64'd0);
        for (int i = 0; i < 16; i++) begin
            wr(64'h300 + 64'(i), i == 5);
            if (i == 5) chk("t4_err", 64'(err), 64'd1);
        end
        chk("t4_avail", 64'(blk_avail), 64'd1);
        chk("t4_last", 64'(blk_last), 64'd0);
        read_block(64'h300, "t4_data", 1'b1);

        // Streaming: writer at 1 word/cycle, reader keeping pace.
        sync_reset();
        fork
            begin
                for (int i = 0; i < 64; i++) wr(64'h400 + 64'(i), 1'b0);
            end
            begin
                for (int b = 0; b < 4; b++) begin
                    int budget;
                    budget = 0;
                    while (!blk_avail && budget < 100) begin
                        tick();
                        budget++;
                    end
                    chk($sformatf("t5_wait_b%0d", b), 64'(blk_avail), 64'd1);
                    read_block(64'h400 + 64'(16 * b), $sformatf("t5_b%0d", b), 1'b1);
                end
            end
        join
        chk("t5_err", 64'(err), 64'd0);
        chk("t5_afull", 64'(afull), 64'd0);
        chk("t5_empty", 64'(blk_avail), 64'd0);

        // Asynchronous reset mid-block.
        sync_reset();
        for (int i = 0; i < 16; i++) wr(64'h600 + 64'(i), i == 3);
        read_block(64'h600, "t6_pre", 1'b0);
        for (int i = 0; i < 7; i++) wr(64'h700 + 64'(i), 1'b0);
        chk("t6_pre_err", 64'(err), 64'd1);
        chk("t6_pre_avail", 64'(blk_avail), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_err", 64'(err), 64'd0);
        chk("t6_async_avail", 64'(blk_avail), 64'd0);
        chk("t6_async_dout", dout, 64'd0);
        chk("t6_async_afull", 64'(afull), 64'd0);
        chk("t6_async_last", 64'(blk_last), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("t6_avail_before", 64'(blk_avail), 64'd0);
            wr(64'h800 + 64'(i), 1'b0);
        end
        chk("t6_avail", 64'(blk_avail), 64'd1);
        read_block(64'h800, "t6_data", 1'b1);
        chk("t6_empty", 64'(blk_avail), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
